// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised VGA raster timing generator. Produces hsync/vsync, display
// enable, pixel coordinates and line/frame strobes from a single system clock.
// A pixel-clock enable (pix_ce) allows slower pixel rates without a second
// clock domain. Every output is registered and updated on the same edge as the
// coordinate counters, so all outputs always describe the x_pos/y_pos that is
// presented in the same cycle.
//
// Ports:
//   clk          in   1    system clock, rising edge
//   rst_n        in   1    asynchronous active-low reset (sync release expected)
//   pix_ce       in   1    pixel clock enable; state advances only when 1
//   hsync        out  1    horizontal sync, asserted level = HSYNC_POL
//   vsync        out  1    vertical sync, asserted level = VSYNC_POL
//   de           out  1    display enable (x < H_ACTIVE and y < V_ACTIVE)
//   x_pos        out  CW   current horizontal count
//   y_pos        out  CW   current vertical count
//   line_start   out  1    one-clk pulse when x_pos becomes 0
//   frame_start  out  1    one-clk pulse when (x_pos,y_pos) becomes (0,0)
//   frame_cnt    out  16   frame counter (only with VGA_TIMING_FRAME_CNT_EN)
//
// Build option:
//   VGA_TIMING_FRAME_CNT_EN  adds frame_cnt, which increments on the same edge
//                            frame_start pulses and wraps 65535 -> 0.
//
// Reset leaves the counters parked on the last pixel of the frame, so the
// first enabled edge after release wraps naturally to (0,0) and raises both
// strobes without any special first-cycle logic.
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CW        = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_ce,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x_pos,
  output logic [CW-1:0] y_pos,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Inclusive upper bounds are used throughout so that a zero back porch
  // (sync ending exactly at H_TOTAL/V_TOTAL) never needs a value that does
  // not fit in CW bits.
  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_LAST = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] V_ACT_LAST = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] HS_FIRST   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LAST    = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LAST    = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  generate
    if (H_SYNC < 1) begin : g_bad_h_sync
      $error("vga_timing_gen: H_SYNC must be at least 1");
    end
    if (V_SYNC < 1) begin : g_bad_v_sync
      $error("vga_timing_gen: V_SYNC must be at least 1");
    end
    if (H_ACTIVE < 1 || V_ACTIVE < 1) begin : g_bad_active
      $error("vga_timing_gen: active area must be at least 1x1");
    end
    if (H_FP < 0 || H_BP < 0 || V_FP < 0 || V_BP < 0) begin : g_bad_porch
      $error("vga_timing_gen: porch values must not be negative");
    end
    if ((H_TOTAL - 1) >= (1 << CW) || (V_TOTAL - 1) >= (1 << CW)) begin : g_bad_cw
      $error("vga_timing_gen: CW too narrow for H_TOTAL-1 / V_TOTAL-1");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Next-position and next-output decode
  // ---------------------------------------------------------------------------
  logic          x_wrap;
  logic          y_wrap;
  logic [CW-1:0] x_next;
  logic [CW-1:0] y_next;
  logic          hs_active;
  logic          vs_active;
  logic          de_next;
  logic          line_start_next;
  logic          frame_start_next;

  // Outputs are decoded from the *next* coordinates so that, once registered,
  // they line up with the counter values in the same cycle.
  always_comb begin
    x_wrap           = (x_pos == H_LAST);
    y_wrap           = (y_pos == V_LAST);
    x_next           = x_pos + 1'b1;
    y_next           = y_pos;
    hs_active        = 1'b0;
    vs_active        = 1'b0;
    de_next          = 1'b0;
    line_start_next  = 1'b0;
    frame_start_next = 1'b0;

    if (x_wrap) begin
      x_next = '0;
      y_next = y_wrap ? '0 : y_pos + 1'b1;
    end

    hs_active        = (x_next >= HS_FIRST) && (x_next <= HS_LAST);
    vs_active        = (y_next >= VS_FIRST) && (y_next <= VS_LAST);
    de_next          = (x_next <= H_ACT_LAST) && (y_next <= V_ACT_LAST);
    line_start_next  = x_wrap;
    frame_start_next = x_wrap && y_wrap;
  end

  // ---------------------------------------------------------------------------
  // Counter and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_pos       <= H_LAST;
      y_pos       <= V_LAST;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      de          <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_ce) begin
      x_pos       <= x_next;
      y_pos       <= y_next;
      hsync       <= hs_active ? HSYNC_POL : ~HSYNC_POL;
      vsync       <= vs_active ? VSYNC_POL : ~VSYNC_POL;
      de          <= de_next;
      line_start  <= line_start_next;
      frame_start <= frame_start_next;
    end else begin
      // Levels hold; strobes are never stretched across disabled cycles.
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  // ---------------------------------------------------------------------------
  // Optional frame counter, advanced on the frame_start edge
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (pix_ce && frame_start_next) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Scoreboard bench for vga_timing_gen using a reduced raster (15x9 total) so
// whole frames fit in a short run. Each driven cycle pushes the expected
// output vector from a behavioural raster model; the vector is popped and
// compared one time unit after the clock edge. Frame-level totals (de, sync
// widths, strobe counts and frame_start period) are checked against values
// computed from the timing parameters.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

  localparam int H_ACTIVE = 8;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 3;
  localparam int H_BP     = 2;
  localparam int V_ACTIVE = 5;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 1;
  localparam bit HSYNC_POL = 1'b0;
  localparam bit VSYNC_POL = 1'b1;
  localparam int CW       = 6;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int F_CLKS  = H_TOTAL * V_TOTAL;
  localparam int OW      = 5 + 2 * CW + 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pix_ce = 1'b0;
  logic          hsync;
  logic          vsync;
  logic          de;
  logic [CW-1:0] x_pos;
  logic [CW-1:0] y_pos;
  logic          line_start;
  logic          frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0]   frame_cnt;
`endif

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE  (H_ACTIVE),
    .H_FP      (H_FP),
    .H_SYNC    (H_SYNC),
    .H_BP      (H_BP),
    .V_ACTIVE  (V_ACTIVE),
    .V_FP      (V_FP),
    .V_SYNC    (V_SYNC),
    .V_BP      (V_BP),
    .HSYNC_POL (HSYNC_POL),
    .VSYNC_POL (VSYNC_POL),
    .CW        (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_ce      (pix_ce),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .x_pos       (x_pos),
    .y_pos       (y_pos),
    .line_start  (line_start),
    .frame_start (frame_start)
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    .frame_cnt   (frame_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural raster model
  // ---------------------------------------------------------------------------
  int          mx;
  int          my;
  logic        m_hs;
  logic        m_vs;
  logic        m_de;
  logic        m_ls;
  logic        m_fs;
  logic [15:0] m_fc;

  logic [OW-1:0] exp_q[$];

  task automatic model_reset();
    mx   = H_TOTAL - 1;
    my   = V_TOTAL - 1;
    m_hs = ~HSYNC_POL;
    m_vs = ~VSYNC_POL;
    m_de = 1'b0;
    m_ls = 1'b0;
    m_fs = 1'b0;
    m_fc = '0;
  endtask

  task automatic model_edge(input logic ce);
    if (!rst_n) begin
      model_reset();
    end else if (ce) begin
      if (mx == H_TOTAL - 1) begin
        mx = 0;
        my = (my == V_TOTAL - 1) ? 0 : my + 1;
      end else begin
        mx = mx + 1;
      end
      m_hs = (mx >= H_ACTIVE + H_FP && mx < H_ACTIVE + H_FP + H_SYNC) ? HSYNC_POL : ~HSYNC_POL;
      m_vs = (my >= V_ACTIVE + V_FP && my < V_ACTIVE + V_FP + V_SYNC) ? VSYNC_POL : ~VSYNC_POL;
      m_de = (mx < H_ACTIVE) && (my < V_ACTIVE);
      m_ls = (mx == 0);
      m_fs = (mx == 0) && (my == 0);
      if (m_fs) m_fc = m_fc + 16'd1;
    end else begin
      m_ls = 1'b0;
      m_fs = 1'b0;
    end
  endtask

  function automatic logic [OW-1:0] pack_exp();
    logic [CW-1:0] xv;
    logic [CW-1:0] yv;
    logic [15:0]   fv;
    xv = mx[CW-1:0];
    yv = my[CW-1:0];
`ifdef VGA_TIMING_FRAME_CNT_EN
    fv = m_fc;
`else
    fv = 16'h0;
`endif
    return {m_hs, m_vs, m_de, m_ls, m_fs, xv, yv, fv};
  endfunction

  function automatic logic [OW-1:0] pack_obs();
    logic [15:0] fv;
`ifdef VGA_TIMING_FRAME_CNT_EN
    fv = frame_cnt;
`else
    fv = 16'h0;
`endif
    return {hsync, vsync, de, line_start, frame_start, x_pos, y_pos, fv};
  endfunction

  // ---------------------------------------------------------------------------
  // Frame statistics (only enabled cycles counted)
  // ---------------------------------------------------------------------------
  int cyc = 0;
  int n_de, n_hs, n_vs, n_ls, n_fs;
  int last_fs, last_period;

  task automatic clear_stats();
    n_de = 0; n_hs = 0; n_vs = 0; n_ls = 0; n_fs = 0;
    last_fs = -1; last_period = -1;
  endtask

  task automatic step(input logic ce, input logic rst);
    logic [OW-1:0] e;
    @(negedge clk);
    rst_n  = rst;
    pix_ce = ce;
    model_edge(ce);
    exp_q.push_back(pack_exp());
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("queue_empty", 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("sb@%0d", cyc), 64'(pack_obs()), 64'(e));
    end
    if (frame_start) begin
      if (last_fs >= 0) last_period = cyc - last_fs;
      last_fs = cyc;
    end
    if (ce) begin
      n_de += int'(de);
      n_hs += int'(hsync == HSYNC_POL);
      n_vs += int'(vsync == VSYNC_POL);
      n_ls += int'(line_start);
      n_fs += int'(frame_start);
    end
    cyc++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();

    // Reset held, pix_ce high: nothing may move.
    repeat (3) step(1'b1, 1'b0);

    // Release with pix_ce high: one full frame starting at (0,0).
    clear_stats();
    repeat (F_CLKS) step(1'b1, 1'b1);
    check("de_per_frame",  64'(n_de), 64'(H_ACTIVE * V_ACTIVE));
    check("hsync_clks",    64'(n_hs), 64'(H_SYNC * V_TOTAL));
    check("vsync_clks",    64'(n_vs), 64'(V_SYNC * H_TOTAL));
    check("line_starts",   64'(n_ls), 64'(V_TOTAL));
    check("frame_starts",  64'(n_fs), 64'd1);

    // Second frame, continuous enable: frame_start period.
    clear_stats();
    last_fs = cyc - F_CLKS;
    repeat (F_CLKS) step(1'b1, 1'b1);
    check("fs_period_ce1", 64'(last_period), 64'(F_CLKS));
`ifdef VGA_TIMING_FRAME_CNT_EN
    check("frame_cnt_2", 64'(frame_cnt), 64'd2);
`endif

    // pix_ce toggling 1/0: two frames take twice the clocks.
    clear_stats();
    for (int i = 0; i < 4 * F_CLKS; i++) step(((i % 2) == 0), 1'b1);
    check("fs_period_tog", 64'(last_period), 64'(2 * F_CLKS));
    check("frames_tog",    64'(n_fs), 64'd2);
    check("de_tog",        64'(n_de), 64'(2 * H_ACTIVE * V_ACTIVE));
    check("lines_tog",     64'(n_ls), 64'(2 * V_TOTAL));

    // Random enable pattern.
    repeat (300) step(1'($urandom_range(0, 1)), 1'b1);

    // Walk to (2,1) and assert reset asynchronously mid-frame.
    for (int i = 0; i < 2 * F_CLKS && !(mx == 2 && my == 1); i++) step(1'b1, 1'b1);
    check("reach_2_1", 64'((mx == 2) && (my == 1)), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_reset", 64'(pack_obs()), 64'(pack_exp()));
    repeat (2) step(1'b1, 1'b0);

    // Clean restart from (0,0) after release.
    clear_stats();
    step(1'b1, 1'b1);
    check("restart_x",  64'(x_pos), 64'd0);
    check("restart_y",  64'(y_pos), 64'd0);
    check("restart_fs", 64'(frame_start), 64'd1);
    repeat (F_CLKS - 1) step(1'b1, 1'b1);
    check("de_restart", 64'(n_de), 64'(H_ACTIVE * V_ACTIVE));
`ifdef VGA_TIMING_FRAME_CNT_EN
    check("frame_cnt_restart", 64'(frame_cnt), 64'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
